arena_frame_rx: RTL and testbench
=================================

// Module: arena_frame_rx
// PURPOSE
//  Receive side of the arena-state serial link. Consumes bytes from the UART receiver
//  (rx_data/rx_valid), de-frames one 100-bit arena snapshot per frame and presents it
//  as a flattened arena_0 bus, with a valid pulse for VGA/debug consumers.
//  Frame = HDR_BYTE, NUM_BYTES data bytes, 1 XOR-checksum byte.
// PARAMETERS
//  NUM_BITS     100      arena bits per frame; NUM_BYTES = ceil(NUM_BITS/8) = 13
//  HDR_BYTE     8'hA5    frame start byte
//  TIMEOUT_CYC  100000   max clk cycles between bytes inside a frame (1 ms @ 100 MHz)
// PORTS
//  clk          in   1         system clock; one clock, all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  i_rx_data    in   8         received byte from UART receiver
//  i_rx_valid   in   1         1-cycle strobe, i_rx_data valid this cycle
//  o_arena_0    out  NUM_BITS  last good arena snapshot, bit i = cell i
//  o_frame_valid out 1         1-cycle pulse: o_arena_0 just updated
//  o_frame_err  out  1         1-cycle pulse: frame discarded (checksum/pad/timeout)
//  o_frame_cnt  out  8         count of good frames, wraps 255->0
//  o_busy       out  1         high while state != HUNT
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=HUNT, o_arena_0=0, shadow=0, byte_idx=0, csum=0,
//   timer=0, o_frame_valid=0, o_frame_err=0, o_frame_cnt=0, o_busy=0. Reset mid-frame
//   abandons the frame with no err pulse.
//  States: HUNT -> DATA -> CHECK -> HUNT.
//  HUNT: on i_rx_valid && i_rx_data==HDR_BYTE -> DATA, byte_idx=0, csum=0, timer=0.
//   Any other byte ignored, no err.
//  DATA: on i_rx_valid: shadow[8k+7:8k] = i_rx_data for k=byte_idx (LSB-first byte
//   order; byte 12 bits [3:0] -> arena[99:96]); csum ^= i_rx_data; byte_idx++.
//   After byte NUM_BYTES-1 -> CHECK. HDR_BYTE inside DATA is ordinary data (no resync).
//  CHECK: on i_rx_valid: good iff i_rx_data == csum AND pad bits of last data byte
//   (bits [7:4] of byte 12) were all 0. Good: o_arena_0<=shadow, o_frame_valid=1,
//   o_frame_cnt++. Bad: o_frame_err=1, o_arena_0 unchanged. Both -> HUNT.
//  Latency: o_arena_0/o_frame_valid/o_frame_err register on the same edge that
//   samples the checksum byte (visible the following cycle); pulses last exactly 1 cycle.
//  Timeout: timer counts clk cycles in DATA/CHECK, cleared on each i_rx_valid; when
//   timer reaches TIMEOUT_CYC-1 without a byte -> HUNT, o_frame_err=1. A byte arriving
//   in the same cycle as expiry is taken as a valid byte (byte wins). Timer idle in HUNT.
//  o_frame_valid and o_frame_err never both high. o_busy = (state != HUNT), registered.
//  i_rx_valid back-to-back every cycle is supported; no backpressure exists.
//  Widths: byte_idx 4 bits, timer $clog2(TIMEOUT_CYC) bits, o_frame_cnt wraps modulo 256.
// TESTING
//  1. A5, bytes 01..0D (byte12=0x0D), csum=XOR -> o_frame_valid 1 cycle, o_arena_0[7:0]=01,
//     [99:96]=D, o_frame_cnt=1.
//  2. Same frame with checksum byte flipped (^0x01) -> o_frame_err pulse, o_arena_0 holds
//     prior value, o_frame_cnt unchanged.
//  3. Byte12=0x1F (pad bit set), correct XOR -> o_frame_err, no update.
//  4. A5 + 5 data bytes then silence TIMEOUT_CYC cycles -> o_frame_err at expiry, o_busy=0;
//     next full good frame accepted normally.
//  5. Leading noise 00,FF,3C then good frame containing A5 as data byte 3 -> single
//     o_frame_valid, arena bits [31:24]=A5.
//  6. rst asserted after 7 data bytes -> all outputs 0 next cycle, no err pulse;
//     256 good frames -> o_frame_cnt wraps to 0.

Source files
------------

// File: rtl/arena_frame_rx.sv
// rtl/arena_frame_rx.sv - de-framer for arena-state snapshots received over the UART link
module arena_frame_rx #(
    parameter int          NUM_BITS    = 100,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic [NUM_BITS-1:0] o_arena_0,
    output logic                o_frame_valid,
    output logic                o_frame_err,
    output logic [7:0]          o_frame_cnt,
    output logic                o_busy
);

    localparam int NUM_BYTES = (NUM_BITS + 7) / 8;
    localparam int SHADOW_W  = NUM_BYTES * 8;
    localparam int TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [SHADOW_W-1:0]   r_shadow;
    logic [NUM_BITS-1:0]   r_arena;
    logic [3:0]            r_byte_idx;
    logic [7:0]            r_csum;
    logic [TW-1:0]         r_timer;
    logic                  r_frame_valid;
    logic                  r_frame_err;
    logic [7:0]            r_frame_cnt;
    logic                  r_busy;

    logic                  w_hdr_seen;
    logic                  w_last_data;
    logic                  w_expire;
    logic                  w_pad_ok;
    logic                  w_good;
    logic                  w_bad;

    // A byte arriving on the expiry cycle suppresses the timeout.
    assign w_hdr_seen  = i_rx_valid && (i_rx_data == HDR_BYTE);
    assign w_last_data = (r_byte_idx == 4'(NUM_BYTES - 1));
    assign w_expire    = (r_state != S_HUNT) && !i_rx_valid
                         && (r_timer == TW'(TIMEOUT_CYC - 1));
    // Bits of the last data byte beyond NUM_BITS must be zero for a frame to count.
    assign w_pad_ok    = ((r_shadow >> NUM_BITS) == '0);
    assign w_good      = (r_state == S_CHECK) && i_rx_valid
                         && (i_rx_data == r_csum) && w_pad_ok;
    assign w_bad       = ((r_state == S_CHECK) && i_rx_valid && !w_good) || w_expire;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: HUNT -> DATA -> CHECK -> HUNT, timeout falls back to HUNT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HUNT: begin
                if (w_hdr_seen) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (i_rx_valid && w_last_data) w_next_state = S_CHECK;
                else if (w_expire)             w_next_state = S_HUNT;
            end
            S_CHECK: begin
                if (i_rx_valid || w_expire) w_next_state = S_HUNT;
            end
            default: w_next_state = S_HUNT;
        endcase
    end

    // Datapath: byte assembly, running checksum, inter-byte timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow      <= '0;
            r_arena       <= '0;
            r_byte_idx    <= '0;
            r_csum        <= '0;
            r_timer       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_valid <= w_good;
            r_frame_err   <= w_bad;
            r_busy        <= (w_next_state != S_HUNT);

            if (r_state == S_HUNT || i_rx_valid || w_expire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                S_HUNT: begin
                    if (w_hdr_seen) begin
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                    end
                end
                S_DATA: begin
                    if (i_rx_valid) begin
                        r_shadow[{r_byte_idx, 3'b000} +: 8] <= i_rx_data;
                        r_csum     <= r_csum ^ i_rx_data;
                        r_byte_idx <= r_byte_idx + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (w_good) begin
                        r_arena     <= r_shadow[NUM_BITS-1:0];
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_arena_0     = r_arena;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_arena_frame_rx.sv
// tb/tb_arena_frame_rx.sv - randomized scoreboard bench for arena_frame_rx
module tb_arena_frame_rx;

    localparam int NB  = 100;
    localparam int NBY = 13;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [NB-1:0] arena;
    logic          frame_valid;
    logic          frame_err;
    logic [7:0]    frame_cnt;
    logic          busy;

    arena_frame_rx #(.NUM_BITS(NB), .HDR_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_arena_0     (arena),
        .o_frame_valid (frame_valid),
        .o_frame_err   (frame_err),
        .o_frame_cnt   (frame_cnt),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            good;
        logic [NB-1:0] arena;
        logic [7:0]    cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // reference model: frame-level view of the link
    bit            m_in;
    logic [7:0]    m_data[$];
    int            m_idle;
    logic [NB-1:0] m_arena;
    logic [7:0]    m_cnt;
    logic [7:0]    fr[NBY];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit good);
        exp_t e;
        e.good  = good;
        e.arena = m_arena;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit r);
        logic [7:0] x;
        if (r) begin
            m_in = 0; m_idle = 0; m_arena = '0; m_cnt = '0; m_data.delete();
        end else if (!m_in) begin
            if (v && d == 8'hA5) begin
                m_in = 1; m_idle = 0; m_data.delete();
            end
        end else if (!v) begin
            m_idle++;
            if (m_idle == TO) begin
                push_exp(0);
                m_in = 0;
            end
        end else begin
            m_idle = 0;
            if (m_data.size() < NBY) begin
                m_data.push_back(d);
            end else begin
                x = 8'h00;
                foreach (m_data[i]) x = x ^ m_data[i];
                if (d == x && m_data[NBY-1][7:4] == 4'h0) begin
                    for (int k = 0; k < NBY; k++)
                        for (int b = 0; b < 8; b++)
                            if (8*k + b < NB) m_arena[8*k + b] = m_data[k][b];
                    m_cnt = m_cnt + 8'd1;
                    push_exp(1);
                end else begin
                    push_exp(0);
                end
                m_in = 0;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        rst = r; rx_valid = v; rx_data = d;
        model_step(v, d, r);
        @(negedge clk);
        check("busy", {127'd0, busy}, {127'd0, m_in});
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'h00, 0);
    endtask

    task automatic gap(input bit rnd);
        int r;
        if (rnd) begin
            r = $urandom_range(0, 99);
            if (r < 80)      idle(0);
            else if (r < 95) idle($urandom_range(1, 3));
            else if (r < 98) idle(TO - 1);
            else             idle(TO);
        end
    endtask

    task automatic send_frame(input logic [7:0] csum_xor, input bit rnd);
        logic [7:0] x;
        x = 8'h00;
        step(1, 8'hA5, 0);
        for (int k = 0; k < NBY; k++) begin
            gap(rnd);
            step(1, fr[k], 0);
            x = x ^ fr[k];
        end
        gap(rnd);
        step(1, x ^ csum_xor, 0);
    endtask

    task automatic count_frame();
        for (int k = 0; k < NBY; k++) fr[k] = 8'(k + 1);
    endtask

    // scoreboard monitor: every output pulse consumes one expected event
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_valid || frame_err) begin
                check("pulse_exclusive", {127'd0, frame_valid && frame_err}, 128'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {127'd0, frame_valid}, {127'd0, ~frame_valid});
                end else begin
                    e = sb.pop_front();
                    check("kind_valid", {127'd0, frame_valid}, {127'd0, e.good});
                    check("arena", {28'd0, arena}, {28'd0, e.arena});
                    check("cnt", {120'd0, frame_cnt}, {120'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        step(0, 8'h00, 1);
        check("rst_arena", {28'd0, arena}, 128'd0);
        check("rst_cnt", {120'd0, frame_cnt}, 128'd0);
        check("rst_pulses", {126'd0, frame_valid, frame_err}, 128'd0);

        // basic good frame
        count_frame();
        send_frame(8'h00, 0);
        check("t1_low_byte", {120'd0, arena[7:0]}, 128'h01);
        check("t1_top_nibble", {124'd0, arena[99:96]}, 128'hD);
        check("t1_cnt", {120'd0, frame_cnt}, 128'd1);
        step(0, 8'h00, 0);
        check("t1_pulse_width", {127'd0, frame_valid}, 128'd0);

        // corrupted checksum
        send_frame(8'h01, 0);
        check("t2_hold", {120'd0, arena[7:0]}, 128'h01);
        check("t2_cnt", {120'd0, frame_cnt}, 128'd1);

        // pad bit set
        fr[12] = 8'h1F;
        send_frame(8'h00, 0);
        check("t3_cnt", {120'd0, frame_cnt}, 128'd1);
        check("t3_top_nibble", {124'd0, arena[99:96]}, 128'hD);

        // timeout after 5 data bytes, then recovery
        step(1, 8'hA5, 0);
        for (int k = 0; k < 5; k++) step(1, 8'(k), 0);
        idle(TO);
        check("t4_busy", {127'd0, busy}, 128'd0);
        count_frame();
        send_frame(8'h00, 0);
        check("t4_cnt", {120'd0, frame_cnt}, 128'd2);

        // noise then header byte value used as data
        step(1, 8'h00, 0); step(1, 8'hFF, 0); step(1, 8'h3C, 0);
        count_frame();
        fr[3] = 8'hA5;
        send_frame(8'h00, 0);
        check("t5_byte3", {120'd0, arena[31:24]}, 128'hA5);
        check("t5_cnt", {120'd0, frame_cnt}, 128'd3);

        // reset mid-frame, then counter wrap
        step(1, 8'hA5, 0);
        for (int k = 0; k < 7; k++) step(1, 8'(k + 7), 0);
        step(0, 8'h00, 1);
        check("t6_arena", {28'd0, arena}, 128'd0);
        check("t6_flags", {125'd0, frame_valid, frame_err, busy}, 128'd0);
        check("t6_cnt", {120'd0, frame_cnt}, 128'd0);
        for (int n = 0; n < 256; n++) begin
            for (int k = 0; k < NBY; k++) fr[k] = 8'($urandom);
            fr[12][7:4] = 4'h0;
            send_frame(8'h00, 0);
        end
        check("t6_wrap", {120'd0, frame_cnt}, 128'd0);

        // randomized frames: noise, gaps around the timeout boundary, bad checksum / pad
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) step(1, 8'($urandom_range(0, 8'hA4)), 0);
            for (int k = 0; k < NBY; k++) fr[k] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fr[12][7:4] = 4'h0;
            send_frame(($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 4));
        end

        idle(4);
        check("sb_drained", sb.size(), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
